// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one word read in flight and hands
// each instruction to decode through a registered slot plus a one-entry buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_re,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        insn_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        KILL
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] req_pc, req_pc_n;
    logic [31:0] buf_data, buf_data_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic        buf_full, buf_full_n;
    logic [31:0] insn_n, pc_n, addr_n;
    logic        valid_n, re_n;
    logic        consume, take, resp_any, issue;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign consume     = insn_valid && !stall;
    assign take        = (state == WAIT) && imem_valid;
    assign resp_any    = (state != IDLE) && imem_valid;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        buf_data_n = buf_data;
        buf_pc_n   = buf_pc;
        buf_full_n = buf_full;
        insn_n     = insn;
        pc_n       = pc;
        valid_n    = insn_valid;
        addr_n     = imem_addr;
        re_n       = 1'b0;
        issue      = 1'b0;

        if (redirect_en) begin
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            valid_n    = 1'b0;
            insn_n     = NOP_INSN;
            buf_full_n = 1'b0;
            // A response landing on the redirect edge closes the request.
            if (resp_any) begin
                state_n = IDLE;
            end else if (state == WAIT) begin
                state_n = KILL;
            end
        end else begin
            if (consume) begin
                if (buf_full) begin
                    insn_n     = buf_data;
                    pc_n       = buf_pc;
                    valid_n    = 1'b1;
                    buf_full_n = take;
                    buf_data_n = take ? imem_rdata : buf_data;
                    buf_pc_n   = take ? req_pc : buf_pc;
                end else if (take) begin
                    insn_n  = imem_rdata;
                    pc_n    = req_pc;
                    valid_n = 1'b1;
                end else begin
                    insn_n  = NOP_INSN;
                    valid_n = 1'b0;
                end
            end else if (take) begin
                if (!insn_valid) begin
                    insn_n  = imem_rdata;
                    pc_n    = req_pc;
                    valid_n = 1'b1;
                end else begin
                    buf_data_n = imem_rdata;
                    buf_pc_n   = req_pc;
                    buf_full_n = 1'b1;
                end
            end

            if (resp_any) begin
                state_n = IDLE;
            end

            issue = run && (state_n == IDLE) && !buf_full_n;
            if (issue) begin
                re_n       = 1'b1;
                addr_n     = fetch_pc;
                req_pc_n   = fetch_pc;
                fetch_pc_n = fetch_pc + 32'd4;
                state_n    = WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            req_pc     <= 32'd0;
            buf_data   <= 32'd0;
            buf_pc     <= 32'd0;
            buf_full   <= 1'b0;
            insn       <= NOP_INSN;
            pc         <= 32'd0;
            insn_valid <= 1'b0;
            imem_re    <= 1'b0;
            imem_addr  <= 32'd0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            req_pc     <= req_pc_n;
            buf_data   <= buf_data_n;
            buf_pc     <= buf_pc_n;
            buf_full   <= buf_full_n;
            insn       <= insn_n;
            pc         <= pc_n;
            insn_valid <= valid_n;
            imem_re    <= re_n;
            imem_addr  <= addr_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a transaction-level memory/redirect model
// queues expected instructions; a negedge monitor pops them on consumption.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk, reset, run, stall, redirect_en;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_valid;
    logic        imem_re, insn_valid;
    logic [31:0] imem_addr, insn, pc;

    fetch_unit #(.RESET_PC(RPC), .NOP_INSN(NOP)) dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .imem_re(imem_re), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .insn(insn), .pc(pc), .insn_valid(insn_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } item_t;

    item_t       exp_q[$];
    item_t       mon_e;
    int          total, passed, delivered;

    // model / knobs
    logic [31:0] model_pc, pend_addr, last_addr, dlv_pc;
    logic        pend, pend_killed, prev_re, prev_run, prev_redir;
    int          lat_cnt, cyc, last_re_cyc, rv_due;
    logic        dlv_due, fast, force_rv;
    int          p_run, p_stall, p_redir, lat_max;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc    = RPC;
        pend        = 1'b0;
        pend_killed = 1'b0;
        prev_re     = 1'b0;
        prev_redir  = 1'b0;
        last_addr   = 32'd0;
        last_re_cyc = 0;
        dlv_due     = 1'b0;
        rv_due      = 0;
    endtask

    task automatic cycle();
        logic  do_valid, do_redir;
        item_t it;
        @(posedge clk);
        #1;
        cyc++;
        do_valid = 1'b0;
        if (dlv_due) begin
            check("dlv_valid", insn_valid, 1'b1);
            check("dlv_pc", pc, dlv_pc);
            dlv_due = 1'b0;
        end
        if (rv_due > 0) begin
            rv_due--;
            if (rv_due == 0) check("redir_valid_reissue", imem_re, 1'b1);
        end
        if (imem_re) begin
            check("re_gap", prev_re, 1'b0);
            check("re_run", prev_run, 1'b1);
            check("re_redir", prev_redir, 1'b0);
            check("re_pend", pend, 1'b0);
            check("re_addr", imem_addr, model_pc);
            check("buf_room", exp_q.size() <= 1, 1'b1);
            if (fast && last_re_cyc > 0) check("re_rate", cyc - last_re_cyc, 2);
            last_re_cyc = cyc;
            pend_addr   = model_pc;
            model_pc    = model_pc + 32'd4;
            pend        = 1'b1;
            pend_killed = 1'b0;
            lat_cnt     = fast ? 1 : $urandom_range(lat_max, 1);
        end else begin
            check("addr_hold", imem_addr, last_addr);
            if (pend) begin
                lat_cnt--;
                if (lat_cnt == 0) do_valid = 1'b1;
            end
        end
        last_addr = imem_addr;
        prev_re   = imem_re;

        run      = ($urandom_range(99, 0) < p_run);
        stall    = ($urandom_range(99, 0) < p_stall);
        do_redir = ($urandom_range(99, 0) < p_redir) || (force_rv && do_valid);
        redirect_en = do_redir;
        redirect_pc = force_rv ? (32'h40 | $urandom_range(3, 0)) : $urandom;
        if (do_redir) begin
            model_pc = {redirect_pc[31:2], 2'b00};
            if (pend) pend_killed = 1'b1;
            exp_q.delete();
            if (force_rv && do_valid) rv_due = 2;
        end
        imem_rdata = $urandom;
        imem_valid = do_valid;
        if (do_valid) begin
            if (!pend_killed) begin
                it.pc   = pend_addr;
                it.data = imem_rdata;
                exp_q.push_back(it);
                if (fast) begin
                    dlv_due = 1'b1;
                    dlv_pc  = pend_addr;
                end
            end
            pend = 1'b0;
        end
        prev_run   = run;
        prev_redir = do_redir;
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_re"}, imem_re, 1'b0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_insn"}, insn, NOP);
        check({tag, "_pc"}, pc, 32'd0);
        check({tag, "_valid"}, insn_valid, 1'b0);
    endtask

    // monitor: consumption happens at an edge with valid, no stall, no redirect
    always @(negedge clk) begin
        if (reset) begin
            if (!insn_valid) begin
                check("idle_nop", insn, NOP);
            end else if (!stall && !redirect_en) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_insn: got pc %h insn %h want none",
                             pc, insn);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("insn", insn, mon_e.data);
                    check("pc", pc, mon_e.pc);
                    delivered++;
                end
            end
        end
    end

    initial begin
        total = 0; passed = 0; delivered = 0; cyc = 0;
        reset = 1'b0; run = 1'b0; stall = 1'b0; redirect_en = 1'b0;
        redirect_pc = 32'd0; imem_rdata = 32'd0; imem_valid = 1'b0;
        fast = 1'b0; force_rv = 1'b0;
        p_run = 100; p_stall = 0; p_redir = 0; lat_max = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_outputs("rst");

        // release with run high: first request on the very next edge
        reset = 1'b1; run = 1'b1; prev_run = 1'b1; fast = 1'b1;
        cycle();
        check("first_re", imem_re, 1'b1);
        check("first_addr", imem_addr, RPC);
        repeat (30) cycle();

        fast = 1'b0; p_run = 90; p_stall = 40; p_redir = 4; lat_max = 3;
        repeat (3000) cycle();
        p_stall = 80;
        repeat (500) cycle();

        p_redir = 0; force_rv = 1'b1; p_run = 100; p_stall = 30;
        repeat (200) cycle();
        force_rv = 1'b0;

        // run=0 drains everything, then sequential resume
        p_run = 0; p_stall = 0;
        repeat (20) cycle();
        check("drain_q", exp_q.size(), 0);
        check("drain_valid", insn_valid, 1'b0);
        check("drain_pend", pend, 1'b0);
        p_run = 100;
        repeat (20) cycle();

        // async reset while a request is outstanding
        p_run = 0;
        repeat (10) cycle();
        p_run = 100; fast = 1'b1; last_re_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (pend && !imem_valid) break;
        end
        check("wait_found", pend, 1'b1);
        reset = 1'b0;
        #2;
        reset_outputs("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1; run = 1'b0; imem_valid = 1'b1; imem_rdata = $urandom;
        model_reset();
        fast = 1'b0;
        @(posedge clk);
        #1;
        check("stray_valid", insn_valid, 1'b0);
        check("stray_re", imem_re, 1'b0);
        imem_valid = 1'b0; run = 1'b1; prev_run = 1'b1;
        cycle();
        check("restart_re", imem_re, 1'b1);
        check("restart_addr", imem_addr, RPC);
        p_stall = 20; lat_max = 3;
        repeat (60) cycle();

        p_run = 0; p_stall = 0;
        repeat (20) cycle();
        check("final_q", exp_q.size(), 0);
        check("final_valid", insn_valid, 1'b0);
        check("delivered", delivered > 100, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
